card_dealer: RTL and testbench

- Upstream card source for the blackjack play/win/lose/bust state machine. It supplies the "random card 1..10" draws that the state machine needs for player and dealer hands.
- Models a single 52-card deck: a free-running LFSR picks cards, and a used-card bitmap guarantees no repeats until reshuffle.
- Keeps running player and dealer hand totals with soft-ace handling, so the state machine compares totals directly (bust > 21, dealer stands ≥ 17).

---
 rtl/card_dealer.sv | 196 +++++++++++++++++++
 tb/tb_card_dealer.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/card_dealer.sv
// Single 52-card deck: free-running LFSR picks a card, a used-card bitmap prevents repeats, and soft-ace hand totals are kept per side.
// A deal completes 2 cycles after the request plus one cycle per used card skipped; requests while busy or with an empty deck are dropped.
module card_dealer #(
  parameter logic [15:0] LFSR_SEED = 16'hACE1,
  parameter int          DECK_SIZE = 52
) (
  input  logic       Clock,
  input  logic       resetn,
  input  logic       shuffle,
  input  logic       clear_hands,
  input  logic       deal_req,
  input  logic       deal_to,
  output logic       busy,
  output logic       deal_valid,
  output logic [3:0] card_rank,
  output logic [1:0] card_suit,
  output logic [3:0] card_value,
  output logic       card_dest,
  output logic [4:0] player_total,
  output logic [4:0] dealer_total,
  output logic       player_soft,
  output logic       dealer_soft,
  output logic [5:0] cards_left,
  output logic       deck_empty
);

  typedef enum logic {IDLE, CHECK} state_e;

  localparam logic [5:0] FULL_DECK = 6'(DECK_SIZE);
  localparam logic [5:0] LAST_CARD = 6'(DECK_SIZE - 1);
  localparam logic [5:0] FOLD_OFS  = 6'(64 - DECK_SIZE);

  state_e                 state_q, state_d;
  logic [15:0]            lfsr_q, lfsr_d;
  logic [DECK_SIZE-1:0]   bitmap_q, bitmap_d;
  logic [5:0]             cand_q, cand_d;
  logic                   dest_q, dest_d;
  logic [5:0]             left_q, left_d;
  logic [3:0]             rank_q, rank_d;
  logic [1:0]             suit_q, suit_d;
  logic [3:0]             value_q, value_d;
  logic                   cdest_q, cdest_d;
  logic                   valid_q, valid_d;
  logic [5:0]             p_hard_q, p_hard_d, d_hard_q, d_hard_d;
  logic                   p_ace_q, p_ace_d, d_ace_q, d_ace_d;

  logic [1:0] suit_c;
  logic [5:0] base_c, off_c;
  logic [3:0] rank_c, value_c;

  function automatic logic [5:0] sat_add(input logic [5:0] hard, input logic [3:0] val);
    logic [6:0] sum;
    sum = {1'b0, hard} + {3'b000, val};
    return sum[6] ? 6'd63 : sum[5:0];
  endfunction

  // Returns {soft, total}: an ace counts 11 only when that keeps the hand at 21 or below.
  function automatic logic [5:0] hand_eval(input logic [5:0] hard, input logic ace);
    logic [6:0] soft_sum;
    soft_sum = {1'b0, hard} + 7'd10;
    if (ace && soft_sum <= 7'd21) return {1'b1, soft_sum[4:0]};
    else if (hard > 6'd31)        return {1'b0, 5'd31};
    else                          return {1'b0, hard[4:0]};
  endfunction

  always_comb begin
    if      (cand_q >= 6'd39) suit_c = 2'd3;
    else if (cand_q >= 6'd26) suit_c = 2'd2;
    else if (cand_q >= 6'd13) suit_c = 2'd1;
    else                      suit_c = 2'd0;
    case (suit_c)
      2'd0:    base_c = 6'd0;
      2'd1:    base_c = 6'd13;
      2'd2:    base_c = 6'd26;
      default: base_c = 6'd39;
    endcase
    off_c   = cand_q - base_c;
    rank_c  = off_c[3:0] + 4'd1;
    value_c = (rank_c > 4'd10) ? 4'd10 : rank_c;
  end

  always_comb begin
    state_d  = state_q;
    lfsr_d   = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
    bitmap_d = bitmap_q;
    cand_d   = cand_q;
    dest_d   = dest_q;
    left_d   = left_q;
    rank_d   = rank_q;
    suit_d   = suit_q;
    value_d  = value_q;
    cdest_d  = cdest_q;
    valid_d  = 1'b0;
    p_hard_d = p_hard_q;
    p_ace_d  = p_ace_q;
    d_hard_d = d_hard_q;
    d_ace_d  = d_ace_q;

    if (shuffle) begin
      state_d  = IDLE;
      bitmap_d = '0;
      left_d   = FULL_DECK;
      p_hard_d = 6'd0;
      p_ace_d  = 1'b0;
      d_hard_d = 6'd0;
      d_ace_d  = 1'b0;
    end else begin
      if (clear_hands) begin
        p_hard_d = 6'd0;
        p_ace_d  = 1'b0;
        d_hard_d = 6'd0;
        d_ace_d  = 1'b0;
      end
      case (state_q)
        IDLE: begin
          if (deal_req && !clear_hands && left_q != 6'd0) begin
            dest_d  = deal_to;
            cand_d  = (lfsr_q[5:0] >= FULL_DECK) ? lfsr_q[5:0] - FOLD_OFS : lfsr_q[5:0];
            state_d = CHECK;
          end
        end
        CHECK: begin
          if (!bitmap_q[cand_q]) begin
            bitmap_d[cand_q] = 1'b1;
            left_d  = left_q - 6'd1;
            rank_d  = rank_c;
            suit_d  = suit_c;
            value_d = value_c;
            cdest_d = dest_q;
            valid_d = 1'b1;
            state_d = IDLE;
            // Builds on the possibly just-cleared hand so a same-cycle clear keeps this card.
            if (dest_q) begin
              d_hard_d = sat_add(d_hard_d, value_c);
              d_ace_d  = d_ace_d | (rank_c == 4'd1);
            end else begin
              p_hard_d = sat_add(p_hard_d, value_c);
              p_ace_d  = p_ace_d | (rank_c == 4'd1);
            end
          end else begin
            cand_d = (cand_q == LAST_CARD) ? 6'd0 : cand_q + 6'd1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge Clock or negedge resetn) begin
    if (!resetn) begin
      state_q  <= IDLE;
      lfsr_q   <= LFSR_SEED;
      bitmap_q <= '0;
      cand_q   <= 6'd0;
      dest_q   <= 1'b0;
      left_q   <= FULL_DECK;
      rank_q   <= 4'd0;
      suit_q   <= 2'd0;
      value_q  <= 4'd0;
      cdest_q  <= 1'b0;
      valid_q  <= 1'b0;
      p_hard_q <= 6'd0;
      p_ace_q  <= 1'b0;
      d_hard_q <= 6'd0;
      d_ace_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      lfsr_q   <= lfsr_d;
      bitmap_q <= bitmap_d;
      cand_q   <= cand_d;
      dest_q   <= dest_d;
      left_q   <= left_d;
      rank_q   <= rank_d;
      suit_q   <= suit_d;
      value_q  <= value_d;
      cdest_q  <= cdest_d;
      valid_q  <= valid_d;
      p_hard_q <= p_hard_d;
      p_ace_q  <= p_ace_d;
      d_hard_q <= d_hard_d;
      d_ace_q  <= d_ace_d;
    end
  end

  assign busy       = (state_q == CHECK);
  assign deal_valid = valid_q;
  assign card_rank  = rank_q;
  assign card_suit  = suit_q;
  assign card_value = value_q;
  assign card_dest  = cdest_q;
  assign cards_left = left_q;
  assign deck_empty = (left_q == 6'd0);
  assign {player_soft, player_total} = hand_eval(p_hard_q, p_ace_q);
  assign {dealer_soft, dealer_total} = hand_eval(d_hard_q, d_ace_q);

endmodule

// File: tb/tb_card_dealer.sv
// Directed bench for card_dealer: hand-computed first cards and blackjack hands, plus a deck/hand scoreboard for full-deck runs.
`timescale 1ns/1ps
module tb_card_dealer;

  localparam logic [15:0] SEED = 16'hACE1;

  logic       Clock = 1'b0;
  logic       resetn = 1'b0;
  logic       shuffle = 1'b0, clear_hands = 1'b0, deal_req = 1'b0, deal_to = 1'b0;
  logic       busy, deal_valid, card_dest, player_soft, dealer_soft, deck_empty;
  logic [3:0] card_rank, card_value;
  logic [1:0] card_suit;
  logic [4:0] player_total, dealer_total;
  logic [5:0] cards_left;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 Clock = ~Clock;

  card_dealer #(.LFSR_SEED(SEED), .DECK_SIZE(52)) dut (
    .Clock(Clock), .resetn(resetn), .shuffle(shuffle), .clear_hands(clear_hands),
    .deal_req(deal_req), .deal_to(deal_to), .busy(busy), .deal_valid(deal_valid),
    .card_rank(card_rank), .card_suit(card_suit), .card_value(card_value),
    .card_dest(card_dest), .player_total(player_total), .dealer_total(dealer_total),
    .player_soft(player_soft), .dealer_soft(dealer_soft), .cards_left(cards_left),
    .deck_empty(deck_empty)
  );

  // Reference Galois LFSR (taps 0xB400), free-running like the deck's picker.
  logic [15:0] m_lfsr;
  always @(posedge Clock or negedge resetn)
    if (!resetn) m_lfsr <= SEED;
    else         m_lfsr <= {1'b0, m_lfsr[15:1]} ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);

  bit used [52];
  int m_left;
  int hard [2];
  bit ace  [2];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  function automatic int fold(input logic [5:0] c);
    return (c >= 6'd52) ? int'(c) - 12 : int'(c);
  endfunction

  function automatic int m_total(input int h, input bit a);
    if (a && h + 10 <= 21) return h + 10;
    if (h > 31) return 31;
    return h;
  endfunction

  function automatic bit m_soft(input int h, input bit a);
    return a && (h + 10 <= 21);
  endfunction

  task automatic model_reset();
    foreach (used[i]) used[i] = 1'b0;
    m_left = 52;
    hard[0] = 0; hard[1] = 0;
    ace[0] = 1'b0; ace[1] = 1'b0;
  endtask

  task automatic model_clear_hands();
    hard[0] = 0; hard[1] = 0;
    ace[0] = 1'b0; ace[1] = 1'b0;
  endtask

  task automatic check_hands(input string tag);
    check({tag, "_ptot"},  player_total, m_total(hard[0], ace[0]));
    check({tag, "_dtot"},  dealer_total, m_total(hard[1], ace[1]));
    check({tag, "_psoft"}, player_soft,  m_soft(hard[0], ace[0]));
    check({tag, "_dsoft"}, dealer_soft,  m_soft(hard[1], ace[1]));
  endtask

  // Requests one card now and checks timing, card and totals against the scoreboard.
  task automatic deal(input bit dest);
    int idx, s, cyc, val;
    bit got;
    idx = fold(m_lfsr[5:0]);
    deal_req = 1'b1;
    deal_to  = dest;
    tick();
    deal_req = 1'b0;
    deal_to  = 1'b0;
    check("busy_after_req", busy, 1);
    s = 0;
    while (used[idx]) begin
      idx = (idx + 1) % 52;
      s++;
    end
    cyc = 0;
    got = 1'b0;
    while (!got && cyc < 60) begin
      tick();
      cyc++;
      if (deal_valid) got = 1'b1;
    end
    check("deal_valid_seen", got, 1);
    check("latency", cyc, 1 + s);
    used[idx] = 1'b1;
    m_left--;
    val = (idx % 13 + 1 > 10) ? 10 : idx % 13 + 1;
    hard[dest] = (hard[dest] + val > 63) ? 63 : hard[dest] + val;
    if (idx % 13 == 0) ace[dest] = 1'b1;
    check("rank",  card_rank,  idx % 13 + 1);
    check("suit",  card_suit,  idx / 13);
    check("value", card_value, val);
    check("dest",  card_dest,  dest);
    check("cards_left", cards_left, m_left);
    check("deck_empty", deck_empty, m_left == 0);
    check_hands("deal");
    tick();
    check("dv_pulse", deal_valid, 0);
  endtask

  // Waits until the free-running picker points at a chosen card, then deals it.
  task automatic deal_card(input int target, input bit dest);
    int w;
    w = 0;
    while (fold(m_lfsr[5:0]) != target && w < 4000) begin
      tick();
      w++;
    end
    check("target_reached", w < 4000, 1);
    deal(dest);
  endtask

  task automatic clear_h();
    clear_hands = 1'b1;
    tick();
    clear_hands = 1'b0;
    model_clear_hands();
    check_hands("clear");
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_busy"},  busy, 0);
    check({tag, "_dv"},    deal_valid, 0);
    check({tag, "_rank"},  card_rank, 0);
    check({tag, "_suit"},  card_suit, 0);
    check({tag, "_value"}, card_value, 0);
    check({tag, "_dest"},  card_dest, 0);
    check({tag, "_ptot"},  player_total, 0);
    check({tag, "_dtot"},  dealer_total, 0);
    check({tag, "_soft"},  {player_soft, dealer_soft}, 0);
    check({tag, "_left"},  cards_left, 52);
    check({tag, "_empty"}, deck_empty, 0);
  endtask

  // Seed 0xACE1 sampled on the first edge after release: cand 33 -> 8 of suit 2.
  task automatic first_card(input string tag);
    deal(1'b0);
    check({tag, "_rank"},  card_rank, 8);
    check({tag, "_suit"},  card_suit, 2);
    check({tag, "_value"}, card_value, 8);
    check({tag, "_ptot"},  player_total, 8);
    check({tag, "_left"},  cards_left, 51);
  endtask

  initial begin
    int dv_cnt, busy_cnt, dut_idx;
    logic [4:0] p_save, d_save;
    bit seen [52];

    model_reset();
    tick();
    tick();
    check_reset_vals("reset");
    resetn = 1'b1;
    first_card("first");

    // Directed hands: player A, 6, K; dealer J, Q, 5.
    clear_h();
    check("clr_ptot", player_total, 0);
    deal_card(0, 1'b0);
    check("ace_tot", player_total, 11);
    check("ace_soft", player_soft, 1);
    deal_card(5, 1'b0);
    check("a6_tot", player_total, 17);
    check("a6_soft", player_soft, 1);
    deal_card(12, 1'b0);
    check("a6k_tot", player_total, 17);
    check("a6k_soft", player_soft, 0);
    deal_card(10, 1'b1);
    deal_card(11, 1'b1);
    check("jq_tot", dealer_total, 20);
    deal_card(4, 1'b1);
    check("bust_tot", dealer_total, 25);
    check("bust_soft", dealer_soft, 0);

    // Shuffle the cycle after a request aborts it.
    deal_req = 1'b1;
    tick();
    deal_req = 1'b0;
    shuffle = 1'b1;
    tick();
    shuffle = 1'b0;
    dv_cnt = deal_valid ? 1 : 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (deal_valid) dv_cnt++;
    end
    model_reset();
    check("shuf_no_dv", dv_cnt, 0);
    check("shuf_busy", busy, 0);
    check("shuf_left", cards_left, 52);
    check("shuf_ptot", player_total, 0);
    check("shuf_dtot", dealer_total, 0);
    check("shuf_rank_held", card_rank, 5);
    check("shuf_suit_held", card_suit, 0);

    // shuffle + clear_hands + deal_req together: only the shuffle acts.
    deal(1'b0);
    shuffle = 1'b1;
    clear_hands = 1'b1;
    deal_req = 1'b1;
    tick();
    shuffle = 1'b0;
    clear_hands = 1'b0;
    deal_req = 1'b0;
    model_reset();
    check("combo_busy", busy, 0);
    dv_cnt = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (deal_valid || busy) dv_cnt++;
    end
    check("combo_no_deal", dv_cnt, 0);
    check("combo_left", cards_left, 52);
    check("combo_ptot", player_total, 0);

    // Whole deck, back to back; late deals exercise the skip scan.
    foreach (seen[i]) seen[i] = 1'b0;
    for (int i = 0; i < 52; i++) begin
      if (i % 3 == 0 && i > 0) clear_h();
      deal(i[0]);
      dut_idx = int'(card_suit) * 13 + int'(card_rank) - 1;
      if (dut_idx >= 0 && dut_idx < 52) begin
        check("unique", seen[dut_idx], 0);
        seen[dut_idx] = 1'b1;
      end else begin
        check("card_in_range", dut_idx, 0);
      end
    end
    check("empty_flag", deck_empty, 1);
    check("empty_left", cards_left, 0);

    // Request on an empty deck is dropped.
    p_save = player_total;
    d_save = dealer_total;
    deal_req = 1'b1;
    tick();
    deal_req = 1'b0;
    dv_cnt = 0;
    busy_cnt = busy ? 1 : 0;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (deal_valid) dv_cnt++;
      if (busy) busy_cnt++;
    end
    check("empty_no_dv", dv_cnt, 0);
    check("empty_no_busy", busy_cnt, 0);
    check("empty_ptot", player_total, p_save);
    check("empty_dtot", dealer_total, d_save);

    // Reset while a deal sits in CHECK.
    shuffle = 1'b1;
    tick();
    shuffle = 1'b0;
    deal_req = 1'b1;
    tick();
    deal_req = 1'b0;
    check("mid_busy", busy, 1);
    resetn = 1'b0;
    #1;
    check_reset_vals("async_rst");
    tick();
    check("rst_no_dv", deal_valid, 0);
    tick();
    model_reset();
    resetn = 1'b1;
    first_card("reseed");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
